// File: rtl/mem_to_uart_tx.sv
// rtl/mem_to_uart_tx.sv - streams NUM_VALUES memory bytes out as 8N1 UART frames
module mem_to_uart_tx #(
    parameter int NUM_VALUES = 4,
    parameter int BASE_ADDR  = 0,
    parameter int ADDR_W     = 6,
    parameter int CNT_W      = 3
) (
    input  logic              slow_clk,
    input  logic              rst,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              tx,
    output logic              busy,
    output logic              done,
    output logic [7:0]        value,
    output logic [CNT_W-1:0]  sent_count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_START = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_STOP  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(NUM_VALUES - 1);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

    logic [2:0]        state_q, state_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0]  byte_idx_q, byte_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        value_q, value_d;
    logic [CNT_W-1:0]  sent_count_q, sent_count_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_en_q, rd_en_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Next-state logic; outputs are derived from the next state so that every
    // output flop already shows the value belonging to the state being entered.
    always_comb begin
        state_d      = state_q;
        bit_idx_d    = bit_idx_q;
        byte_idx_d   = byte_idx_q;
        shift_d      = shift_q;
        value_d      = value_q;
        sent_count_d = sent_count_q;
        rd_addr_d    = rd_addr_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_FETCH;
                    byte_idx_d   = '0;
                    sent_count_d = '0;
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                // Registered memory delivers the byte during WAIT; latch it as
                // START is entered so value changes only in START.
                state_d = S_START;
                shift_d = rd_data;
                value_d = rd_data;
            end
            S_START: begin
                state_d   = S_DATA;
                bit_idx_d = 3'd0;
            end
            S_DATA: begin
                if (bit_idx_q == 3'd7) begin
                    state_d = S_STOP;
                end else begin
                    bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            S_STOP: begin
                sent_count_d = sent_count_q + CNT_W'(1);
                if (byte_idx_q == LAST_BYTE) begin
                    state_d = S_DONE;
                end else begin
                    byte_idx_d = byte_idx_q + CNT_W'(1);
                    state_d    = S_FETCH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        rd_en_d = (state_d == S_FETCH);
        if (state_d == S_FETCH) begin
            // Address wraps naturally at 2^ADDR_W.
            rd_addr_d = BASE + ADDR_W'(byte_idx_d);
        end

        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[bit_idx_d];
            default: tx_d = 1'b1;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and registered outputs; reset aborts immediately and idles the line.
    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            bit_idx_q    <= 3'd0;
            byte_idx_q   <= '0;
            shift_q      <= 8'd0;
            value_q      <= 8'd0;
            sent_count_q <= '0;
            rd_addr_q    <= BASE;
            rd_en_q      <= 1'b0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_idx_q    <= bit_idx_d;
            byte_idx_q   <= byte_idx_d;
            shift_q      <= shift_d;
            value_q      <= value_d;
            sent_count_q <= sent_count_d;
            rd_addr_q    <= rd_addr_d;
            rd_en_q      <= rd_en_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign rd_en      = rd_en_q;
    assign rd_addr    = rd_addr_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign value      = value_q;
    assign sent_count = sent_count_q;

endmodule

// File: tb/tb_mem_to_uart_tx.sv
// tb/tb_mem_to_uart_tx.sv - directed self-checking bench for mem_to_uart_tx
module tb_mem_to_uart_tx;

    logic       slow_clk = 1'b0;
    logic       rst      = 1'b1;
    logic       start    = 1'b0;
    logic       rd_en;
    logic [5:0] rd_addr;
    logic [7:0] rd_data  = 8'd0;
    logic       tx;
    logic       busy;
    logic       done;
    logic [7:0] value;
    logic [2:0] sent_count;

    logic [7:0] mem [0:63];

    int checks   = 0;
    int failures = 0;

    logic       tx_tr   [$];
    logic       en_tr   [$];
    logic       done_tr [$];
    logic [7:0] val_tr  [$];
    logic [2:0] cnt_tr  [$];
    logic [5:0] addr_tr [$];
    logic [7:0] rx_bytes[$];
    int         stop_err;

    mem_to_uart_tx dut (
        .slow_clk   (slow_clk),
        .rst        (rst),
        .start      (start),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .tx         (tx),
        .busy       (busy),
        .done       (done),
        .value      (value),
        .sent_count (sent_count)
    );

    always #5 slow_clk = ~slow_clk;

    // Registered memory: data valid one edge after the read request.
    always @(posedge slow_clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_traces();
        tx_tr.delete(); en_tr.delete(); done_tr.delete();
        val_tr.delete(); cnt_tr.delete(); addr_tr.delete();
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge slow_clk);
            tx_tr.push_back(tx);
            en_tr.push_back(rd_en);
            done_tr.push_back(done);
            val_tr.push_back(value);
            cnt_tr.push_back(sent_count);
            if (rd_en) addr_tr.push_back(rd_addr);
        end
    endtask

    task automatic decode();
        int i;
        logic [7:0] b;
        rx_bytes.delete();
        stop_err = 0;
        i = 0;
        while (i + 9 < tx_tr.size()) begin
            if (tx_tr[i] == 1'b0) begin
                for (int j = 0; j < 8; j++) b[j] = tx_tr[i + 1 + j];
                rx_bytes.push_back(b);
                if (tx_tr[i + 9] !== 1'b1) stop_err++;
                i = i + 10;
            end else begin
                i++;
            end
        end
    endtask

    function automatic int count_done();
        int c = 0;
        foreach (done_tr[k]) if (done_tr[k] === 1'b1) c++;
        return c;
    endfunction

    function automatic int first_done();
        foreach (done_tr[k]) if (done_tr[k] === 1'b1) return k;
        return -1;
    endfunction

    task automatic check_four_bytes(input string tag);
        logic [7:0] exp_b [4];
        exp_b = '{8'h05, 8'hA3, 8'hFF, 8'h00};
        decode();
        check({tag, "_nframes"}, rx_bytes.size(), 4);
        check({tag, "_stop"}, stop_err, 0);
        check({tag, "_naddr"}, addr_tr.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < rx_bytes.size()) check($sformatf("%s_byte%0d", tag, k), rx_bytes[k], exp_b[k]);
            if (k < addr_tr.size())  check($sformatf("%s_addr%0d", tag, k), addr_tr[k], k);
        end
    endtask

    initial begin
        logic [12:0] fr;
        for (int a = 0; a < 64; a++) mem[a] = 8'hEE;
        mem[0] = 8'h05; mem[1] = 8'hA3; mem[2] = 8'hFF; mem[3] = 8'h00;

        // Reset values
        tick(3);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_value", value, 0);
        check("rst_cnt", sent_count, 0);
        rst = 1'b0;
        tick(2);

        // Single transfer with a one-cycle start pulse
        clear_traces();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(59);
        check_four_bytes("t1");
        check("t1_fetch0", en_tr[0], 1);
        check("t1_ndone", count_done(), 1);
        check("t1_done_at", first_done(), 48);
        check("t1_busy_done", 32'(busy), 0);
        check("t1_cnt_final", sent_count, 4);
        check("t1_val_wait1", val_tr[13], 8'h05);
        check("t1_val_start1", val_tr[14], 8'hA3);
        fr = '0;
        for (int k = 0; k < 13; k++) fr = {fr[11:0], tx_tr[14 + k]};
        check("t1_frame_a3", fr, 13'b0110001011110);

        // Start pulse at cycle 20 while busy is ignored
        clear_traces();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(19);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(50);
        check_four_bytes("t2");
        check("t2_ndone", count_done(), 1);

        // Start held high: back-to-back transfers
        clear_traces();
        start = 1'b1;
        tick(51);
        start = 1'b0;
        tick(60);
        decode();
        check("t3_nframes", rx_bytes.size(), 8);
        check("t3_ndone", count_done(), 2);
        check("t3_done_at", first_done(), 48);
        check("t3_cnt_in_done", cnt_tr[48], 4);
        check("t3_idle_gap", en_tr[49], 0);
        check("t3_fetch2", en_tr[50], 1);
        check("t3_cnt_cleared", cnt_tr[50], 0);
        check("t3_naddr", addr_tr.size(), 8);

        // Reset during DATA bit 3 of byte 1
        clear_traces();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(18);
        check("t4_tx_low_pre", tx_tr[18], 0);
        check("t4_busy_pre", busy, 1);
        #1 rst = 1'b1;
        #1;
        check("t4_tx_async", tx, 1);
        check("t4_busy_async", busy, 0);
        check("t4_done_async", done, 0);
        check("t4_rd_en_async", rd_en, 0);
        check("t4_cnt_async", sent_count, 0);
        check("t4_value_async", value, 0);
        tick(2);
        rst = 1'b0;
        tick(10);
        check("t4_no_done", count_done(), 0);
        check("t4_idle_busy", busy, 0);
        clear_traces();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(59);
        check_four_bytes("t4r");
        check("t4r_done_at", first_done(), 48);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
